// File: rtl/spi_master_fifo_if.sv
// Bus-side and pin-side signal bundle for spi_master_fifo.
// Optional receive signals are present when SPI_MASTER_RX_EN is defined.
interface spi_master_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic              wr;
   logic [DATA_W:0]   wdata;
   logic [DIV_W-1:0]  div;
   logic              cpol;
   logic              cpha;
   logic              clr_ovf;
   logic              busy;
   logic              full;
   logic              ovf;
   logic [LW-1:0]     level;
   logic              sck;
   logic              sdo;
   logic              cs_;
   logic              dc_;
`ifdef SPI_MASTER_RX_EN
   logic              sdi;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;

   modport master (
      output wr, wdata, div, cpol, cpha, clr_ovf, sdi,
      input  busy, full, ovf, level, sck, sdo, cs_, dc_, rx_data, rx_valid
   );
   modport slave (
      input  wr, wdata, div, cpol, cpha, clr_ovf, sdi,
      output busy, full, ovf, level, sck, sdo, cs_, dc_, rx_data, rx_valid
   );
`else
   modport master (
      output wr, wdata, div, cpol, cpha, clr_ovf,
      input  busy, full, ovf, level, sck, sdo, cs_, dc_
   );
   modport slave (
      input  wr, wdata, div, cpol, cpha, clr_ovf,
      output busy, full, ovf, level, sck, sdo, cs_, dc_
   );
`endif
endinterface

// File: rtl/spi_master_fifo.sv
// SPI master with TX FIFO, run-time divider and all four CPOL/CPHA modes.
// Define SPI_MASTER_RX_EN to add the sdi receive path (rx_data/rx_valid).
module spi_master_fifo #(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              reset_,
   spi_master_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = $clog2(2 * DATA_W + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state;
   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   logic              push;
   logic              pop;
   logic              full_c;
   logic              empty_c;
   logic [DIV_W-1:0]  div_l;
   logic [DIV_W-1:0]  cnt;
   logic              tick;
   logic              cpha_l;
   logic [EW-1:0]     edges;
   logic [DATA_W-1:0] shreg;
   logic              sck_r;
   logic              sdo_r;
   logic              cs_r;
   logic              dc_r;
   logic              ovf_r;
`ifdef SPI_MASTER_RX_EN
   logic [DATA_W-1:0] rx_sh;
   logic [DATA_W-1:0] rx_data_r;
   logic              rx_valid_r;
`endif

   assign full_c  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty_c = (count == '0);
   assign push    = bus.wr && !full_c;
   assign pop     = (state == IDLE) && !empty_c;
   assign tick    = (cnt == div_l);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.wdata;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf_r <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
         // A dropped push in the same cycle as clr_ovf keeps the flag set.
         if (bus.wr && full_c) ovf_r <= 1'b1;
         else if (bus.clr_ovf) ovf_r <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state  <= IDLE;
         cnt    <= '0;
         div_l  <= '0;
         cpha_l <= 1'b0;
         edges  <= '0;
         shreg  <= '0;
         sck_r  <= 1'b0;
         sdo_r  <= 1'b0;
         cs_r   <= 1'b1;
         dc_r   <= 1'b0;
`ifdef SPI_MASTER_RX_EN
         rx_sh      <= '0;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
`endif
      end else begin
`ifdef SPI_MASTER_RX_EN
         rx_valid_r <= 1'b0;
`endif
         if (state != IDLE) cnt <= tick ? '0 : cnt + DIV_W'(1);
         case (state)
            IDLE: begin
               sck_r <= bus.cpol;
               cnt   <= '0;
               if (!empty_c) begin
                  div_l  <= bus.div;
                  cpha_l <= bus.cpha;
                  cs_r   <= 1'b0;
                  dc_r   <= mem[rptr][DATA_W];
                  shreg  <= mem[rptr][DATA_W-1:0];
                  if (!bus.cpha) sdo_r <= mem[rptr][DATA_W-1];
                  state  <= SETUP;
               end
            end
            SETUP: if (tick) begin
               edges <= EW'(2 * DATA_W);
               state <= SHIFT;
            end
            SHIFT: if (tick) begin
               sck_r <= ~sck_r;
               edges <= edges - EW'(1);
               // Even remaining-edge count marks a leading edge.
               if (!edges[0]) begin
                  if (cpha_l) begin
                     sdo_r <= shreg[DATA_W-1];
                     shreg <= shreg << 1;
                  end
               end else if (!cpha_l && edges != EW'(1)) begin
                  sdo_r <= shreg[DATA_W-2];
                  shreg <= shreg << 1;
               end
`ifdef SPI_MASTER_RX_EN
               if ((~edges[0]) ^ cpha_l) rx_sh <= {rx_sh[DATA_W-2:0], bus.sdi};
`endif
               if (edges == EW'(1)) state <= HOLD;
            end
            HOLD: if (tick) begin
               cs_r  <= 1'b1;
               state <= GAP;
`ifdef SPI_MASTER_RX_EN
               rx_data_r  <= rx_sh;
               rx_valid_r <= 1'b1;
`endif
            end
            GAP: if (tick) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = !empty_c || (state != IDLE);
   assign bus.full  = full_c;
   assign bus.ovf   = ovf_r;
   assign bus.level = count;
   assign bus.sck   = sck_r;
   assign bus.sdo   = sdo_r;
   assign bus.cs_   = cs_r;
   assign bus.dc_   = dc_r;
`ifdef SPI_MASTER_RX_EN
   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
`endif
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: frame table plus FIFO, reset and queueing sequences.
// With SPI_MASTER_RX_EN defined, sdo is looped back to sdi and the receive path is checked too.
module tb_spi_master_fifo;
   localparam int DATA_W     = 8;
   localparam int DIV_W      = 8;
   localparam int FIFO_DEPTH = 4;

   logic clk    = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   spi_master_fifo_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   spi_master_fifo #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

`ifdef SPI_MASTER_RX_EN
   assign bus.sdi = bus.sdo;
`endif

   typedef struct {
      logic              cpol;
      logic              cpha;
      logic [DIV_W-1:0]  div;
      logic [DATA_W:0]   wdata;
      logic [DATA_W-1:0] exp_data;
      logic              exp_dc;
      int unsigned       exp_len;
   } vec_t;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      logic [DATA_W-1:0] got;
      int unsigned n, len, nbits;
      logic prev;
`ifdef SPI_MASTER_RX_EN
      int unsigned rx_early;
      rx_early = 0;
`endif
      @(negedge clk);
      bus.cpol = v.cpol;
      bus.cpha = v.cpha;
      bus.div  = v.div;
      repeat (3) @(negedge clk);
      check($sformatf("idle_sck[%0d]", idx), bus.sck, v.cpol);
      bus.wr    = 1'b1;
      bus.wdata = v.wdata;
      @(negedge clk);
      bus.wr = 1'b0;
      n = 0;
      while (bus.cs_ && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("cs_latency[%0d]", idx), n, 1);
      check($sformatf("dc[%0d]", idx), bus.dc_, v.exp_dc);
      got   = '0;
      nbits = 0;
      len   = 0;
      prev  = bus.sck;
      while (!bus.cs_ && len < 5000) begin
         len++;
`ifdef SPI_MASTER_RX_EN
         if (bus.rx_valid) rx_early++;
`endif
         @(negedge clk);
         if (bus.sck != prev && ((bus.sck != v.cpol) == !v.cpha)) begin
            got = {got[DATA_W-2:0], bus.sdo};
            nbits++;
         end
         prev = bus.sck;
      end
      check($sformatf("frame_len[%0d]", idx), len, v.exp_len);
      check($sformatf("bits[%0d]", idx), nbits, DATA_W);
      check($sformatf("data[%0d]", idx), got, v.exp_data);
      check($sformatf("end_sck[%0d]", idx), bus.sck, v.cpol);
`ifdef SPI_MASTER_RX_EN
      check($sformatf("rx_valid_rise[%0d]", idx), bus.rx_valid, 1);
      check($sformatf("rx_data[%0d]", idx), bus.rx_data, v.exp_data);
      check($sformatf("rx_early[%0d]", idx), rx_early, 0);
      @(negedge clk);
      check($sformatf("rx_valid_pulse[%0d]", idx), bus.rx_valid, 0);
`endif
      repeat (v.div + 3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [7];
      int unsigned n, e, gap, tail, busy_lo, ph, cs_lo, busy_hi;
      logic prev;

      vecs[0] = '{1'b0, 1'b0, 8'd24, 9'h1A5, 8'hA5, 1'b1, 450};
      vecs[1] = '{1'b0, 1'b0, 8'd0,  9'h03C, 8'h3C, 1'b0, 18};
      vecs[2] = '{1'b0, 1'b1, 8'd0,  9'h03C, 8'h3C, 1'b0, 18};
      vecs[3] = '{1'b1, 1'b0, 8'd0,  9'h03C, 8'h3C, 1'b0, 18};
      vecs[4] = '{1'b1, 1'b1, 8'd0,  9'h03C, 8'h3C, 1'b0, 18};
      vecs[5] = '{1'b1, 1'b1, 8'd3,  9'h15A, 8'h5A, 1'b1, 72};
      vecs[6] = '{1'b0, 1'b1, 8'd2,  9'h0F1, 8'hF1, 1'b0, 54};

      bus.wr      = 1'b0;
      bus.wdata   = '0;
      bus.div     = '0;
      bus.cpol    = 1'b0;
      bus.cpha    = 1'b0;
      bus.clr_ovf = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_sck", bus.sck, 0);
      check("rst_sdo", bus.sdo, 0);
      check("rst_cs", bus.cs_, 1);
      check("rst_dc", bus.dc_, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_full", bus.full, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_level", bus.level, 0);
      reset_ = 1'b1;

      for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

      // FIFO fill and overflow while a slow frame runs
      @(negedge clk);
      bus.div  = 8'd24;
      bus.cpol = 1'b0;
      bus.cpha = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.wr    = 1'b1;
         bus.wdata = 9'h010 + 9'(i);
         @(negedge clk);
      end
      bus.wr = 1'b0;
      check("level_after4", bus.level, 3);
      check("full_after4", bus.full, 0);
      check("busy_after4", bus.busy, 1);
      bus.wr = 1'b1;
      @(negedge clk);
      check("level_after5", bus.level, 4);
      check("full_after5", bus.full, 1);
      check("ovf_after5", bus.ovf, 0);
      @(negedge clk);
      check("ovf_after6", bus.ovf, 1);
      check("level_after6", bus.level, 4);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      check("ovf_set_wins", bus.ovf, 1);
      bus.wr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", bus.ovf, 0);
      bus.clr_ovf = 1'b0;

      // Abort mid-frame after the bit-3 sampling edge
      n = 0;
      e = 0;
      prev = bus.sck;
      while (e < 7 && n < 2000) begin
         @(negedge clk);
         n++;
         if (bus.sck != prev) e++;
         prev = bus.sck;
      end
      check("reach_bit3", e, 7);
      check("sck_high_before_rst", bus.sck, 1);
      #2 reset_ = 1'b0;
      #1;
      check("abort_cs", bus.cs_, 1);
      check("abort_sck", bus.sck, 0);
      check("abort_level", bus.level, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_full", bus.full, 0);
      @(negedge clk);
      reset_ = 1'b1;
      cs_lo   = 0;
      busy_hi = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.cs_) cs_lo++;
         if (bus.busy) busy_hi++;
      end
      check("no_resume_cs", cs_lo, 0);
      check("no_resume_busy", busy_hi, 0);

      // Two queued frames: inter-frame gap and busy span
      bus.div = 8'd2;
      repeat (3) @(negedge clk);
      bus.wr    = 1'b1;
      bus.wdata = 9'h081;
      @(negedge clk);
      check("busy_first", bus.busy, 1);
      bus.wdata = 9'h042;
      @(negedge clk);
      bus.wr = 1'b0;
      ph = 0; gap = 0; tail = 0; busy_lo = 0; n = 0;
      while (ph < 5 && n < 1000) begin
         case (ph)
            0: if (!bus.cs_) ph = 1;
            1: if (bus.cs_) begin ph = 2; gap = 1; end
            2: if (bus.cs_) gap++; else ph = 3;
            3: if (bus.cs_) begin ph = 4; tail = 1; end
            4: if (bus.busy) tail++; else ph = 5;
            default: ;
         endcase
         if (ph < 5 && !bus.busy) busy_lo++;
         if (ph < 5) begin
            @(negedge clk);
            n++;
         end
      end
      check("queue_done", ph, 5);
      check("cs_gap", gap, 4);
      check("busy_tail", tail, 3);
      check("busy_dropout", busy_lo, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
